// File: rtl/eg_slot_scheduler_pkg.sv
// Shared constants for the VM2413 envelope front end.
// Slot/stage limits and rhythm key bit positions.
package vm2413;

  localparam logic [4:0] SLOT_LAST = 5'd17;

  localparam logic [1:0] STAGE_0 = 2'd0;
  localparam logic [1:0] STAGE_1 = 2'd1;
  localparam logic [1:0] STAGE_2 = 2'd2;
  localparam logic [1:0] STAGE_3 = 2'd3;

  localparam int RHY_BD  = 4;
  localparam int RHY_SD  = 3;
  localparam int RHY_TOM = 2;
  localparam int RHY_TC  = 1;
  localparam int RHY_HH  = 0;

endpackage

// File: rtl/eg_slot_scheduler_counter.sv
// Slot/stage time-division counter.
// Flags the frame wrap one edge ahead so commits can line up with it.
module slot_stage_counter
  import vm2413::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clkena,
  output logic [4:0] slot,
  output logic [1:0] stage,
  output logic [4:0] slot_nxt,
  output logic       wrap_next,
  output logic       frame_start
);

  logic [1:0] stage_nxt;

  always_comb begin
    slot_nxt  = slot;
    stage_nxt = stage;
    wrap_next = 1'b0;
    if (clkena) begin
      stage_nxt = stage + 2'd1;
      if (stage == STAGE_3) begin
        if (slot == SLOT_LAST) begin
          slot_nxt  = 5'd0;
          wrap_next = 1'b1;
        end else begin
          slot_nxt = slot + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot        <= 5'd0;
      stage       <= STAGE_0;
      frame_start <= 1'b1;
    end else if (clkena) begin
      slot        <= slot_nxt;
      stage       <= stage_nxt;
      frame_start <= wrap_next;
    end
  end

endmodule

// File: rtl/eg_slot_scheduler.sv
// Slot sequencer with frame-synchronous key/rhythm snapshot.
// CPU writes land in shadow regs and are committed at each frame wrap.
module eg_slot_scheduler
  import vm2413::*;
#(
  parameter int NUM_CH = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clkena,
  input  logic       key_wr,
  input  logic [3:0] key_ch,
  input  logic       key_val,
  input  logic       rhy_wr,
  input  logic       rhy_en,
  input  logic [4:0] rhy_bits,
  output logic [4:0] slot,
  output logic [1:0] stage,
  output logic       key,
  output logic       rhythm,
  output logic       frame_start
);

  logic [4:0]        slot_nxt;
  logic              wrap_next;

  logic [NUM_CH-1:0] sh_key, sh_key_nxt;
  logic              sh_rhy_en, sh_rhy_en_nxt;
  logic [4:0]        sh_rhy, sh_rhy_nxt;

  logic [NUM_CH-1:0] c_key, c_key_nxt;
  logic              c_rhy_en, c_rhy_en_nxt;
  logic [4:0]        c_rhy, c_rhy_nxt;

  logic              k_base;
  logic              key_nxt;

  slot_stage_counter u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clkena     (clkena),
    .slot       (slot),
    .stage      (stage),
    .slot_nxt   (slot_nxt),
    .wrap_next  (wrap_next),
    .frame_start(frame_start)
  );

  always_comb begin
    sh_key_nxt    = sh_key;
    sh_rhy_en_nxt = sh_rhy_en;
    sh_rhy_nxt    = sh_rhy;
    if (key_wr && (key_ch < 4'(NUM_CH)))
      sh_key_nxt[key_ch] = key_val;
    if (rhy_wr) begin
      sh_rhy_en_nxt = rhy_en;
      sh_rhy_nxt    = rhy_bits;
    end
  end

  // Commit uses the shadow next values so a write on the wrap edge counts.
  always_comb begin
    c_key_nxt    = c_key;
    c_rhy_en_nxt = c_rhy_en;
    c_rhy_nxt    = c_rhy;
    if (wrap_next) begin
      c_key_nxt    = sh_key_nxt;
      c_rhy_en_nxt = sh_rhy_en_nxt;
      c_rhy_nxt    = sh_rhy_nxt;
    end
  end

  always_comb begin
    k_base  = c_key_nxt[slot_nxt[4:1]];
    key_nxt = k_base;
    if (c_rhy_en_nxt) begin
      unique case (slot_nxt)
        5'd12, 5'd13: key_nxt = k_base | c_rhy_nxt[RHY_BD];
        5'd14:        key_nxt = k_base | c_rhy_nxt[RHY_HH];
        5'd15:        key_nxt = k_base | c_rhy_nxt[RHY_SD];
        5'd16:        key_nxt = k_base | c_rhy_nxt[RHY_TOM];
        5'd17:        key_nxt = k_base | c_rhy_nxt[RHY_TC];
        default:      key_nxt = k_base;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_key    <= '0;
      sh_rhy_en <= 1'b0;
      sh_rhy    <= '0;
      c_key     <= '0;
      c_rhy_en  <= 1'b0;
      c_rhy     <= '0;
      key       <= 1'b0;
    end else begin
      sh_key    <= sh_key_nxt;
      sh_rhy_en <= sh_rhy_en_nxt;
      sh_rhy    <= sh_rhy_nxt;
      c_key     <= c_key_nxt;
      c_rhy_en  <= c_rhy_en_nxt;
      c_rhy     <= c_rhy_nxt;
      if (clkena)
        key <= key_nxt;
    end
  end

  assign rhythm = c_rhy_en;

endmodule

// File: doc/eg_slot_scheduler.md
# eg_slot_scheduler

Sequencer and key/rhythm scheduler in front of `EnvelopeGenerator`. It generates the 18-slot × 4-stage time-division sequence (`slot`, `stage`) on every `clkena` tick. It accepts asynchronous CPU-side key-on/off and rhythm register writes and presents a per-slot `key` and `rhythm` that change only at frame boundaries. Every slot in a frame therefore sees a consistent key snapshot.

## Interface
Parameters:
- `NUM_CH`, 9: number of melodic channels; slots = 2·NUM_CH = 18.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `clkena`  in  1  sequencing enable; the sequencer advances only on cycles where it is 1.
- `key_wr`  in  1  one-cycle write strobe for a channel key bit.
- `key_ch`  in  4  channel index 0..8 for `key_wr`.
- `key_val`  in  1  new key-on value for `key_ch`.
- `rhy_wr`  in  1  one-cycle write strobe for the rhythm register.
- `rhy_en`  in  1  rhythm mode enable.
- `rhy_bits`  in  5  {BD, SD, TOM, TC, HH} key bits, with bit4 = BD.
- `slot`  out  5  current slot, 0..17.
- `stage`  out  2  current stage, 0..3.
- `key`  out  1  key state for the current `slot`.
- `rhythm`  out  1  committed rhythm-mode enable.
- `frame_start`  out  1  high for the single `clkena` period in which slot=0 and stage=0.

## Operation
- **Counter.** On each `clk` edge with `clkena`=1:
  - `stage` increments.
  - When `stage` = 3, it wraps to 0 and `slot` increments.
  - When `slot` = 17 and `stage` = 3, both wrap to 0.
  - A frame is 72 `clkena` ticks.
- **Shadow registers.** `sh_key[8:0]`, `sh_rhy_en`, and `sh_rhy[4:0]` are written on any clock where `key_wr` or `rhy_wr` is 1, independent of `clkena`.
  - A write with `key_ch` > 8 is ignored.
  - Repeated writes within a frame: the last one wins.
  - `key_wr` and `rhy_wr` in the same cycle both take effect.
- **Commit.** On the edge where the counter wraps to slot 0/stage 0, the committed set `c_key`, `c_rhy_en`, `c_rhy` loads the shadow *next* values. A write landing on the commit edge is included.
- **Key mapping.** Slot s belongs to channel ch = s/2. s even = modulator, s odd = carrier.
  - `key` = `c_key[ch]`, except when `c_rhy_en`=1:
  - slots 12, 13: `c_key[6]` | BD
  - slot 14: `c_key[7]` | HH
  - slot 15: `c_key[7]` | SD
  - slot 16: `c_key[8]` | TOM
  - slot 17: `c_key[8]` | TC
- **Outputs.** `key` is computed from the *next* slot and committed values and registered with `slot`. It is therefore constant for all 4 stages of a slot.
- **Rhythm output.** `rhythm` = `c_rhy_en`.
- **Frame marker.** `frame_start` is registered: it is 1 while slot=0 and stage=0, and 0 otherwise.

## Timing
- **Reset.** Asynchronous. While reset is asserted and after release:
  - `slot`=0, `stage`=0, `key`=0, `rhythm`=0, `frame_start`=1.
  - All shadow and committed registers are 0.
  - The first frame begins at the first `clkena` after release.
- **Output latency.** Outputs are registered. The values for tick n are stable throughout the period between `clkena` edges n and n+1.
- **Write-to-effect latency.** A write becomes visible at the next frame wrap: from 1 to 72 `clkena` ticks after the write.
- **`clkena` held low.** Counter, commit and outputs freeze. Writes are still captured in the shadow registers.
- **Reset mid-frame.** The counter returns to 0/0 and pending shadow writes are discarded.
- **Rhythm disable at commit.** Slots 12–17 revert to plain `c_key` mapping in that same frame.

## Structure
- **Shared package `vm2413`** holds:
  - `SLOT_LAST` = 5'd17
  - the `STAGE_*` constants 0..3
  - the rhythm bit indices `RHY_BD`=4, `RHY_SD`=3, `RHY_TOM`=2, `RHY_TC`=1, `RHY_HH`=0
- **Sub-module.** One sub-module is natural: `slot_stage_counter`, containing the wrap logic plus `wrap_next` and `frame_start` generation. Key mapping and the shadow/commit registers stay in the top level.

## Test plan
- **Reset and frame length.** Reset, then `clkena`=1 for 144 clocks → `slot`/`stage` run 0/0..17/3 twice; `frame_start` is high exactly at ticks 0 and 72; `key`=0 throughout.
- **Deferred key-on.** At slot 5/stage 2, `key_wr` with ch=3, val=1 → `key`=0 for the rest of this frame; `key`=1 for slots 6 and 7 of the next frame and 0 for all other slots.
- **Rhythm mapping.** `rhy_wr` with en=1, bits=5'b01001 (SD, HH) → from the next frame, `key`=1 at slots 14 and 15 only, and `rhythm`=1; with en=0 the same bits give no keys.
- **Last write wins and invalid channel.** `key_wr` ch=9 val=1, then ch=2 val=1, then ch=2 val=0 in one frame → no slot keyed next frame.
- **`clkena` gaps.** `clkena` toggled 1-of-3 → sequence identical per tick; a write during `clkena`=0 is committed at the next wrap.
- **Reset mid-operation.** Assert reset at slot 9 with a pending write → outputs return to the reset values immediately; after release the write is not applied.
